// File: rtl/ppu_bg_fetch_sequencer_pkg.sv
// Shared definitions for the background fetch sequencer: fetch phases, default
// VRAM layout constants and the attribute quadrant selector.
package ppu_bg_fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    PhNtAddr  = 3'd0,
    PhNtRead  = 3'd1,
    PhAtAddr  = 3'd2,
    PhAtRead  = 3'd3,
    PhPtlAddr = 3'd4,
    PhPtlRead = 3'd5,
    PhPthAddr = 3'd6,
    PhPthRead = 3'd7
  } phase_e;

  localparam logic [13:0] NtBaseDefault   = 14'h2000;
  localparam logic [9:0]  AtOffsetDefault = 10'h3C0;

  // Each attribute byte covers a 4x4-tile block; {coarse_y[1], coarse_x[1]} picks its 2x2 quadrant.
  function automatic logic [1:0] at_quadrant(input logic [7:0] data, input logic cy1,
                                             input logic cx1);
    logic [1:0] sel;
    logic [1:0] res;
    sel = {cy1, cx1};
    unique case (sel)
      2'b00:   res = data[1:0];
      2'b01:   res = data[3:2];
      2'b10:   res = data[5:4];
      default: res = data[7:6];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ppu_bg_fetch_sequencer_tile_stream.sv
// Holds the last completed tile and presents it one bit per dot to the four
// background Shift8 registers, leftmost pixel first.
module ppu_bg_fetch_sequencer_tile_stream (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  input  logic       enable,
  input  logic       capture,
  input  logic [7:0] pat_lo,
  input  logic [7:0] pat_hi,
  input  logic [1:0] attr,
  input  logic [2:0] phase,
  output logic       shift,
  output logic       load,
  output logic       pat_lo_bit,
  output logic       pat_hi_bit,
  output logic       attr_lo_bit,
  output logic       attr_hi_bit
);

  logic [7:0] lo_q;
  logic [7:0] hi_q;
  logic [1:0] attr_q;
  logic       valid_q;
  logic [2:0] bit_idx;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      lo_q    <= '0;
      hi_q    <= '0;
      attr_q  <= '0;
      valid_q <= 1'b0;
    end else if (capture) begin
      lo_q    <= pat_lo;
      hi_q    <= pat_hi;
      attr_q  <= attr;
      valid_q <= 1'b1;
    end
  end

  // Until the first tile after a restart is captured, load stays low so Shift8 fills with zeros.
  assign shift       = enable & ~restart & ~reset;
  assign load        = shift & valid_q;
  assign bit_idx     = 3'd7 - phase;
  assign pat_lo_bit  = lo_q[bit_idx];
  assign pat_hi_bit  = hi_q[bit_idx];
  assign attr_lo_bit = attr_q[0];
  assign attr_hi_bit = attr_q[1];

endmodule

// File: rtl/ppu_bg_fetch_sequencer.sv
// PPU background fetch sequencer: 8-dot NT/AT/pattern fetch slots feeding a serial tile stream.
// Define PPU_BG_FETCH_DEBUG_EN to add the registered o_debug_tile snapshot output.
module ppu_bg_fetch_sequencer
  import ppu_bg_fetch_sequencer_pkg::*;
#(
  parameter logic [13:0] NT_BASE   = NtBaseDefault,
  parameter logic [9:0]  AT_OFFSET = AtOffsetDefault
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_restart,
  input  logic [4:0]  i_coarse_x,
  input  logic [4:0]  i_coarse_y,
  input  logic [2:0]  i_fine_y,
  input  logic [1:0]  i_nametable_sel,
  input  logic        i_pattern_sel,
  input  logic [7:0]  i_vram_data,
  output logic [13:0] o_vram_addr,
  output logic        o_vram_rd,
  output logic        o_shift,
  output logic        o_load,
  output logic        o_pat_lo_bit,
  output logic        o_pat_hi_bit,
  output logic        o_attr_lo_bit,
  output logic        o_attr_hi_bit,
  output logic        o_tile_done,
  output logic [2:0]  o_phase
`ifdef PPU_BG_FETCH_DEBUG_EN
  ,
  output logic [31:0] o_debug_tile
`endif
);

  phase_e     phase_q, phase_d;
  logic [7:0] nt_q, nt_d;
  logic [1:0] at_q, at_d;
  logic [7:0] ptl_q, ptl_d;
  logic [7:0] pth_q, pth_d;
  logic       capture;
  logic [13:0] nt_page;

  assign nt_page = NT_BASE | {2'b00, i_nametable_sel, 10'b0};

  always_comb begin
    phase_d     = phase_q;
    nt_d        = nt_q;
    at_d        = at_q;
    ptl_d       = ptl_q;
    pth_d       = pth_q;
    o_vram_addr = '0;
    o_vram_rd   = 1'b0;
    o_tile_done = 1'b0;
    if (i_restart) begin
      phase_d = PhNtAddr;
      nt_d    = '0;
      at_d    = '0;
      ptl_d   = '0;
      pth_d   = '0;
    end else if (i_enable) begin
      phase_d = phase_e'(phase_q + 3'd1);
      unique case (phase_q)
        PhNtAddr: begin
          o_vram_addr = nt_page | {4'b0, i_coarse_y, i_coarse_x};
          o_vram_rd   = 1'b1;
        end
        PhNtRead: nt_d = i_vram_data;
        PhAtAddr: begin
          o_vram_addr = nt_page | {4'b0, AT_OFFSET} | {8'b0, i_coarse_y[4:2], i_coarse_x[4:2]};
          o_vram_rd   = 1'b1;
        end
        PhAtRead: at_d = at_quadrant(i_vram_data, i_coarse_y[1], i_coarse_x[1]);
        PhPtlAddr: begin
          o_vram_addr = {1'b0, i_pattern_sel, nt_q, 1'b0, i_fine_y};
          o_vram_rd   = 1'b1;
        end
        PhPtlRead: ptl_d = i_vram_data;
        PhPthAddr: begin
          o_vram_addr = {1'b0, i_pattern_sel, nt_q, 1'b1, i_fine_y};
          o_vram_rd   = 1'b1;
        end
        PhPthRead: begin
          pth_d       = i_vram_data;
          o_tile_done = 1'b1;
        end
        default: ;
      endcase
    end
    // Reset dominates: keep the bus and strobes quiet while it is held.
    if (i_reset) begin
      o_vram_addr = '0;
      o_vram_rd   = 1'b0;
      o_tile_done = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      phase_q <= PhNtAddr;
      nt_q    <= '0;
      at_q    <= '0;
      ptl_q   <= '0;
      pth_q   <= '0;
    end else begin
      phase_q <= phase_d;
      nt_q    <= nt_d;
      at_q    <= at_d;
      ptl_q   <= ptl_d;
      pth_q   <= pth_d;
    end
  end

  assign o_phase = phase_q;
  // The high pattern byte is taken straight off the bus so the tile is complete on the phase-7 edge.
  assign capture = i_enable & ~i_restart & ~i_reset & (phase_q == PhPthRead);

  ppu_bg_fetch_sequencer_tile_stream u_stream (
    .clk         (i_clk),
    .reset       (i_reset),
    .restart     (i_restart),
    .enable      (i_enable),
    .capture     (capture),
    .pat_lo      (ptl_q),
    .pat_hi      (i_vram_data),
    .attr        (at_q),
    .phase       (phase_q),
    .shift       (o_shift),
    .load        (o_load),
    .pat_lo_bit  (o_pat_lo_bit),
    .pat_hi_bit  (o_pat_hi_bit),
    .attr_lo_bit (o_attr_lo_bit),
    .attr_hi_bit (o_attr_hi_bit)
  );

`ifdef PPU_BG_FETCH_DEBUG_EN
  logic [31:0] debug_q;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_restart) begin
      debug_q <= '0;
    end else begin
      debug_q <= {nt_q, 6'b0, at_q, ptl_q, pth_q};
    end
  end

  assign o_debug_tile = debug_q;
`endif

endmodule
